// File: rtl/primus_decode_stage.sv
// primus_decode_stage
// -------------------
// RV32I instruction decode stage sitting between fetch and execute.
//
// An instruction and its PC are taken from fetch over a valid/ready
// handshake, decoded combinationally, and the resulting control bundle is
// held in an output register backed by a one-entry skid register. Together
// they hold up to two instructions. if_ready_o depends only on the skid
// occupancy flop, so there is no combinational path from id_ready_i back to
// fetch.
//
// Handshake rule (both sides): a transfer happens on a rising clk_i edge
// where valid and ready are both 1. A producer holding valid=1 must keep its
// payload stable until the transfer. id_valid_o and the id_* bundle are
// stable while id_valid_o && !id_ready_i.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   flush_i                 discard everything held; same-cycle input dropped
//   if_valid_i/if_ready_o   fetch-side handshake
//   if_instr_i, if_pc_i     raw instruction word and its PC
//   id_valid_o/id_ready_i   execute-side handshake
//   id_pc_o                 PC of the presented instruction
//   id_rs1_o/rs2_o/rd_o     register indices
//   id_imm_o                sign-extended immediate (0 for OP/SYSTEM)
//   id_alu_op_o             alu_op_e
//   id_funct3_o             instr[14:12]
//   id_funct7b5_o           instr[30]
//   id_alu_src_imm_o        ALU operand B is the immediate
//   id_alu_src_pc_o         ALU operand A is the PC
//   id_reg_write_o          write rd (never for x0 or illegal)
//   id_mem_read_o/write_o   LOAD / STORE
//   id_branch_o/id_jump_o   BRANCH / JAL or JALR
//   id_wb_sel_o             wb_sel_e
//   id_system_o             SYSTEM opcode
//   id_illegal_o            unknown opcode or instr[1:0] != 2'b11

module primus_decode_stage #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [31:0]     if_instr_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [XLEN-1:0] id_pc_o,
    output logic [4:0]      id_rs1_o,
    output logic [4:0]      id_rs2_o,
    output logic [4:0]      id_rd_o,
    output logic [XLEN-1:0] id_imm_o,
    output logic [1:0]      id_alu_op_o,
    output logic [2:0]      id_funct3_o,
    output logic            id_funct7b5_o,
    output logic            id_alu_src_imm_o,
    output logic            id_alu_src_pc_o,
    output logic            id_reg_write_o,
    output logic            id_mem_read_o,
    output logic            id_mem_write_o,
    output logic            id_branch_o,
    output logic            id_jump_o,
    output logic [1:0]      id_wb_sel_o,
    output logic            id_system_o,
    output logic            id_illegal_o
);

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_JAL_R  = 7'b1100111,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_ADD        = 2'd0,
        ALU_SUB        = 2'd1,
        ALU_FROM_FUNCT = 2'd2,
        ALU_PASS_B     = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        alu_op_e         alu_op;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic            alu_src_imm;
        logic            alu_src_pc;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        wb_sel_e         wb_sel;
        logic            system;
        logic            illegal;
    } bundle_t;

    // Reset image: all-zero encodes ALU_ADD / WB_ALU, only the PC differs.
    function automatic bundle_t reset_bundle();
        bundle_t b;
        b    = '0;
        b.pc = RESET_PC[XLEN-1:0];
        return b;
    endfunction

    bundle_t dec;
    bundle_t out_q;
    bundle_t skid_q;
    logic    out_valid_q;
    logic    skid_valid_q;
    logic    accept;
    logic    load_out;

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign imm_i = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
    assign imm_s = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
    assign imm_b = {{19{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7],
                    if_instr_i[30:25], if_instr_i[11:8], 1'b0};
    assign imm_u = {if_instr_i[31:12], 12'b0};
    assign imm_j = {{11{if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12],
                    if_instr_i[20], if_instr_i[30:21], 1'b0};

    // Decoder. Register fields and funct bits pass through even for illegal
    // words so the trap handler downstream can inspect them.
    always_comb begin
        dec          = '0;
        dec.pc       = if_pc_i;
        dec.rs1      = if_instr_i[19:15];
        dec.rs2      = if_instr_i[24:20];
        dec.rd       = if_instr_i[11:7];
        dec.funct3   = if_instr_i[14:12];
        dec.funct7b5 = if_instr_i[30];
        case (if_instr_i[6:0])
            OPC_LOAD: begin
                dec.imm         = imm_i;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
                dec.mem_read    = 1'b1;
                dec.wb_sel      = WB_MEM;
            end
            OPC_STORE: begin
                dec.imm         = imm_s;
                dec.alu_src_imm = 1'b1;
                dec.mem_write   = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.imm         = imm_i;
                dec.alu_op      = ALU_FROM_FUNCT;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
            end
            OPC_OP: begin
                dec.alu_op    = ALU_FROM_FUNCT;
                dec.reg_write = 1'b1;
            end
            OPC_LUI: begin
                dec.imm         = imm_u;
                dec.alu_op      = ALU_PASS_B;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
            end
            OPC_AUIPC: begin
                dec.imm         = imm_u;
                dec.alu_src_imm = 1'b1;
                dec.alu_src_pc  = 1'b1;
                dec.reg_write   = 1'b1;
            end
            OPC_BRANCH: begin
                dec.imm    = imm_b;
                dec.alu_op = ALU_SUB;
                dec.branch = 1'b1;
            end
            OPC_JAL: begin
                dec.imm         = imm_j;
                dec.alu_src_imm = 1'b1;
                dec.alu_src_pc  = 1'b1;
                dec.reg_write   = 1'b1;
                dec.jump        = 1'b1;
                dec.wb_sel      = WB_PC4;
            end
            OPC_JAL_R: begin
                dec.imm         = imm_i;
                dec.alu_src_imm = 1'b1;
                dec.reg_write   = 1'b1;
                dec.jump        = 1'b1;
                dec.wb_sel      = WB_PC4;
            end
            OPC_SYSTEM: begin
                dec.system = 1'b1;
            end
            // Covers unknown opcodes and any word with instr[1:0] != 2'b11,
            // since every listed opcode ends in 2'b11.
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        if (if_instr_i[11:7] == 5'd0) begin
            dec.reg_write = 1'b0;
        end
    end

    assign if_ready_o = !skid_valid_q;
    assign accept     = if_valid_i && if_ready_o;
    assign load_out   = !out_valid_q || id_ready_i;

    // Skid is only filled while the output is stalled, and fetch is
    // blocked while it is full, so the skid entry is always the older of
    // the two when the output frees up: ordering is preserved.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= reset_bundle();
            skid_q       <= reset_bundle();
        end else if (flush_i) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (load_out) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q       <= dec;
            skid_valid_q <= 1'b1;
        end
    end

    assign id_valid_o       = out_valid_q;
    assign id_pc_o          = out_q.pc;
    assign id_rs1_o         = out_q.rs1;
    assign id_rs2_o         = out_q.rs2;
    assign id_rd_o          = out_q.rd;
    assign id_imm_o         = out_q.imm;
    assign id_alu_op_o      = out_q.alu_op;
    assign id_funct3_o      = out_q.funct3;
    assign id_funct7b5_o    = out_q.funct7b5;
    assign id_alu_src_imm_o = out_q.alu_src_imm;
    assign id_alu_src_pc_o  = out_q.alu_src_pc;
    assign id_reg_write_o   = out_q.reg_write;
    assign id_mem_read_o    = out_q.mem_read;
    assign id_mem_write_o   = out_q.mem_write;
    assign id_branch_o      = out_q.branch;
    assign id_jump_o        = out_q.jump;
    assign id_wb_sel_o      = out_q.wb_sel;
    assign id_system_o      = out_q.system;
    assign id_illegal_o     = out_q.illegal;

endmodule

// File: tb/tb_primus_decode_stage.sv
// Testbench for primus_decode_stage: directed scenario tasks plus a
// scoreboard that predicts every output bundle from a reference decoder.
module tb_primus_decode_stage;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  localparam logic [1:0] A_ADD = 2'd0, A_SUB = 2'd1, A_FN = 2'd2, A_PB = 2'd3;
  localparam logic [1:0] W_ALU = 2'd0, W_MEM = 2'd1, W_PC4 = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic [1:0]  wb_sel;
    logic        system;
    logic        illegal;
  } bundle_t;

  localparam int BW = $bits(bundle_t);

  logic clk, rst_i, flush_i;
  logic if_valid_i, if_ready_o;
  logic [31:0] if_instr_i, if_pc_i;
  logic id_valid_o, id_ready_i;
  logic [31:0] id_pc_o, id_imm_o;
  logic [4:0] id_rs1_o, id_rs2_o, id_rd_o;
  logic [1:0] id_alu_op_o, id_wb_sel_o;
  logic [2:0] id_funct3_o;
  logic id_funct7b5_o, id_alu_src_imm_o, id_alu_src_pc_o, id_reg_write_o;
  logic id_mem_read_o, id_mem_write_o, id_branch_o, id_jump_o;
  logic id_system_o, id_illegal_o;

  logic [BW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  bundle_t act;

  primus_decode_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
    .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
    .id_pc_o(id_pc_o), .id_rs1_o(id_rs1_o), .id_rs2_o(id_rs2_o), .id_rd_o(id_rd_o),
    .id_imm_o(id_imm_o), .id_alu_op_o(id_alu_op_o), .id_funct3_o(id_funct3_o),
    .id_funct7b5_o(id_funct7b5_o), .id_alu_src_imm_o(id_alu_src_imm_o),
    .id_alu_src_pc_o(id_alu_src_pc_o), .id_reg_write_o(id_reg_write_o),
    .id_mem_read_o(id_mem_read_o), .id_mem_write_o(id_mem_write_o),
    .id_branch_o(id_branch_o), .id_jump_o(id_jump_o), .id_wb_sel_o(id_wb_sel_o),
    .id_system_o(id_system_o), .id_illegal_o(id_illegal_o)
  );

  assign act = {id_pc_o, id_rs1_o, id_rs2_o, id_rd_o, id_imm_o, id_alu_op_o,
                id_funct3_o, id_funct7b5_o, id_alu_src_imm_o, id_alu_src_pc_o,
                id_reg_write_o, id_mem_read_o, id_mem_write_o, id_branch_o,
                id_jump_o, id_wb_sel_o, id_system_o, id_illegal_o};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference decoder ----------------
  function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    bundle_t b;
    logic [31:0] ii, is, ib, iu, ij;
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu = {ins[31:12], 12'b0};
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    b = '0;
    b.pc = pc; b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.rd = ins[11:7];
    b.funct3 = ins[14:12]; b.funct7b5 = ins[30];
    case (ins[6:0])
      7'h03: begin b.imm = ii; b.alu_src_imm = 1; b.reg_write = 1; b.mem_read = 1; b.wb_sel = W_MEM; end
      7'h23: begin b.imm = is; b.alu_src_imm = 1; b.mem_write = 1; end
      7'h13: begin b.imm = ii; b.alu_op = A_FN; b.alu_src_imm = 1; b.reg_write = 1; end
      7'h33: begin b.alu_op = A_FN; b.reg_write = 1; end
      7'h37: begin b.imm = iu; b.alu_op = A_PB; b.alu_src_imm = 1; b.reg_write = 1; end
      7'h17: begin b.imm = iu; b.alu_src_imm = 1; b.alu_src_pc = 1; b.reg_write = 1; end
      7'h63: begin b.imm = ib; b.alu_op = A_SUB; b.branch = 1; end
      7'h6F: begin b.imm = ij; b.alu_src_imm = 1; b.alu_src_pc = 1; b.reg_write = 1; b.jump = 1; b.wb_sel = W_PC4; end
      7'h67: begin b.imm = ii; b.alu_src_imm = 1; b.reg_write = 1; b.jump = 1; b.wb_sel = W_PC4; end
      7'h73: b.system = 1;
      default: b.illegal = 1;
    endcase
    if (ins[11:7] == 5'd0) b.reg_write = 0;
    return b;
  endfunction

  // ---------------- scoreboard ----------------
  // Sampled on the falling edge: the presented bundle must match the queue
  // head; it is retired when id_ready_i is high, and an accepted input is
  // predicted and queued. A flush empties the prediction queue.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (id_valid_o) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got bundle pc=%h, expected no valid output", id_pc_o);
        end else begin
          if (act !== exp_q[0]) begin
            n_err++;
            $display("FAIL sb_bundle: got %h expected %h", act, exp_q[0]);
          end
          if (id_ready_i) void'(exp_q.pop_front());
        end
      end
      if (flush_i) exp_q.delete();
      else if (if_valid_i && if_ready_o) exp_q.push_back(ref_decode(if_instr_i, if_pc_i));
    end
  end

  // ---------------- driver tasks ----------------
  // Present one instruction with execute ready; returns #1 after the edge
  // that accepted it, when the bundle is on the outputs.
  task automatic send_one(input logic [31:0] ins, input logic [31:0] pc);
    @(posedge clk); #1;
    if_valid_i = 1; if_instr_i = ins; if_pc_i = pc; id_ready_i = 1;
    @(posedge clk); #1;
    if_valid_i = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    #12;
    n_vec++;
    if ({id_valid_o, if_ready_o, id_pc_o, id_imm_o, id_alu_op_o, id_wb_sel_o,
         id_reg_write_o, id_illegal_o, id_rd_o, id_jump_o} !==
        {1'b0, 1'b1, RESET_PC, 32'h0, A_ADD, W_ALU, 1'b0, 1'b0, 5'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b rdy=%b pc=%h imm=%h", id_valid_o, if_ready_o, id_pc_o, id_imm_o);
    end
    @(posedge clk); #1 rst_i = 0;
  endtask

  task automatic test_addi;
    send_one(32'hFFF00293, 32'h100);
    n_vec++;
    if ({id_valid_o, id_rd_o, id_imm_o, id_alu_op_o, id_alu_src_imm_o, id_reg_write_o, id_wb_sel_o} !==
        {1'b1, 5'd5, 32'hFFFFFFFF, A_FN, 1'b1, 1'b1, W_ALU}) begin
      n_err++;
      $display("FAIL addi: got v=%b rd=%0d imm=%h op=%0d, expected v=1 rd=5 imm=ffffffff op=2", id_valid_o, id_rd_o, id_imm_o, id_alu_op_o);
    end
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    id_ready_i = 0; if_valid_i = 1; if_instr_i = 32'h0082A303; if_pc_i = 32'h200;
    @(posedge clk); #1;
    n_vec++;
    if (if_ready_o !== 1'b1) begin
      n_err++; $display("FAIL b2b_ready_first: got %b expected 1", if_ready_o);
    end
    if_instr_i = 32'h0062A423; if_pc_i = 32'h204;
    @(posedge clk); #1;
    if_valid_i = 0;
    n_vec++;
    if ({if_ready_o, id_valid_o, id_pc_o, id_mem_read_o} !== {1'b0, 1'b1, 32'h200, 1'b1}) begin
      n_err++; $display("FAIL b2b_full: got rdy=%b v=%b pc=%h expected rdy=0 v=1 pc=200", if_ready_o, id_valid_o, id_pc_o);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({if_ready_o, id_pc_o, id_imm_o, id_rd_o} !== {1'b0, 32'h200, 32'h8, 5'd6}) begin
      n_err++; $display("FAIL b2b_hold: got pc=%h imm=%h rd=%0d expected pc=200 imm=8 rd=6", id_pc_o, id_imm_o, id_rd_o);
    end
    id_ready_i = 1;
    @(posedge clk); #1;
    n_vec++;
    if ({id_valid_o, id_pc_o, id_imm_o, id_mem_write_o, id_reg_write_o, if_ready_o} !==
        {1'b1, 32'h204, 32'h8, 1'b1, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL b2b_sw: got pc=%h imm=%h mw=%b rw=%b expected pc=204 imm=8 mw=1 rw=0", id_pc_o, id_imm_o, id_mem_write_o, id_reg_write_o);
    end
    @(posedge clk); #1;
    n_vec++;
    if (id_valid_o !== 1'b0) begin
      n_err++; $display("FAIL b2b_empty: got valid=%b expected 0", id_valid_o);
    end
  endtask

  task automatic test_branch_jal;
    send_one(32'hFE000EE3, 32'h300);
    n_vec++;
    // instr[7]=1 supplies imm[11], so the offset is -4.
    if ({id_branch_o, id_alu_op_o, id_imm_o, id_reg_write_o, id_jump_o} !== {1'b1, A_SUB, 32'hFFFFFFFC, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL beq: got br=%b op=%0d imm=%h expected br=1 op=1 imm=fffffffc", id_branch_o, id_alu_op_o, id_imm_o);
    end
    send_one(32'h008000EF, 32'h304);
    n_vec++;
    if ({id_jump_o, id_wb_sel_o, id_imm_o, id_rd_o, id_reg_write_o, id_alu_src_pc_o} !== {1'b1, W_PC4, 32'h8, 5'd1, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL jal: got j=%b wb=%0d imm=%h rd=%0d expected j=1 wb=2 imm=8 rd=1", id_jump_o, id_wb_sel_o, id_imm_o, id_rd_o);
    end
  endtask

  task automatic test_illegal;
    send_one(32'h0000007F, 32'h310);
    n_vec++;
    if ({id_valid_o, id_illegal_o, id_reg_write_o, id_mem_read_o, id_mem_write_o, id_branch_o, id_jump_o} !== 7'b1100000) begin
      n_err++; $display("FAIL illegal_opc: got ill=%b rw=%b expected ill=1 rw=0", id_illegal_o, id_reg_write_o);
    end
    send_one(32'h000000B0, 32'h314);
    n_vec++;
    if ({id_illegal_o, id_reg_write_o} !== 2'b10) begin
      n_err++; $display("FAIL illegal_low_bits: got ill=%b rw=%b expected ill=1 rw=0", id_illegal_o, id_reg_write_o);
    end
    send_one(32'h00000013, 32'h318);
    n_vec++;
    if ({id_valid_o, id_illegal_o, id_reg_write_o, id_alu_src_imm_o} !== 4'b1001) begin
      n_err++; $display("FAIL nop: got ill=%b rw=%b expected ill=0 rw=0", id_illegal_o, id_reg_write_o);
    end
  endtask

  task automatic test_flush;
    @(posedge clk); #1;
    id_ready_i = 0; if_valid_i = 1; if_instr_i = 32'h00100093; if_pc_i = 32'h400;
    @(posedge clk); #1 if_pc_i = 32'h404;
    @(posedge clk); #1;
    n_vec++;
    if ({if_ready_o, id_valid_o} !== 2'b01) begin
      n_err++; $display("FAIL flush_setup: got rdy=%b v=%b expected rdy=0 v=1", if_ready_o, id_valid_o);
    end
    flush_i = 1; if_pc_i = 32'h408;
    @(posedge clk); #1;
    flush_i = 0; if_valid_i = 0;
    n_vec++;
    if ({id_valid_o, if_ready_o} !== 2'b01) begin
      n_err++; $display("FAIL flush_full: got v=%b rdy=%b expected v=0 rdy=1", id_valid_o, if_ready_o);
    end
    id_ready_i = 1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (id_valid_o !== 1'b0) begin
      n_err++; $display("FAIL flush_no_reappear: got v=%b expected 0", id_valid_o);
    end
    // One held, and the flush coincides with an accepted input.
    id_ready_i = 0; if_valid_i = 1; if_pc_i = 32'h500;
    @(posedge clk); #1;
    flush_i = 1; if_pc_i = 32'h504;
    @(posedge clk); #1;
    flush_i = 0; if_valid_i = 0; id_ready_i = 1;
    n_vec++;
    if ({id_valid_o, if_ready_o} !== 2'b01) begin
      n_err++; $display("FAIL flush_concurrent: got v=%b rdy=%b expected v=0 rdy=1", id_valid_o, if_ready_o);
    end
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (id_valid_o !== 1'b0) begin
      n_err++; $display("FAIL flush_dropped_input: got v=%b expected 0", id_valid_o);
    end
  endtask

  task automatic test_async_reset;
    @(posedge clk); #1;
    id_ready_i = 0; if_valid_i = 1; if_instr_i = 32'h00C00513; if_pc_i = 32'h600;
    @(posedge clk); #1 if_pc_i = 32'h604;
    @(posedge clk); #1 if_valid_i = 0;
    @(posedge clk); #3;
    rst_i = 1;
    #1;
    n_vec++;
    if ({id_valid_o, if_ready_o, id_pc_o, id_imm_o} !== {1'b0, 1'b1, RESET_PC, 32'h0}) begin
      n_err++; $display("FAIL async_reset: got v=%b rdy=%b pc=%h expected v=0 rdy=1 pc=%h", id_valid_o, if_ready_o, id_pc_o, RESET_PC);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_i = 0; id_ready_i = 1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (id_valid_o !== 1'b0) begin
      n_err++; $display("FAIL reset_no_partial: got v=%b expected 0", id_valid_o);
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [6:0] ops [12];
    logic [31:0] r;
    ops = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h67, 7'h73, 7'h0F, 7'h7F};
    r = $urandom();
    r[6:0] = ops[$urandom_range(0, 11)];
    if ($urandom_range(0, 19) == 0) r[1:0] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  task automatic test_random;
    int accepted = 0;
    int cycles = 0;
    logic acc;
    logic [31:0] pc = 32'h1000;
    while (accepted < 1000 && cycles < 20000) begin
      @(negedge clk) acc = if_valid_i && if_ready_o;
      @(posedge clk); #1;
      if (acc) begin accepted++; pc += 4; end
      if (acc || !if_valid_i) begin
        if_valid_i = ($urandom_range(0, 3) != 0);
        if_instr_i = gen_instr();
        if_pc_i = pc;
      end
      id_ready_i = ($urandom_range(0, 2) != 0);
      cycles++;
    end
    if_valid_i = 0;
    n_vec++;
    if (accepted < 1000) begin
      n_err++; $display("FAIL random_timeout: got %0d accepted, expected 1000", accepted);
    end
    id_ready_i = 1;
    for (int i = 0; i < 50 && (exp_q.size() != 0 || id_valid_o); i++) @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0 || id_valid_o !== 1'b0) begin
      n_err++; $display("FAIL random_drain: got %0d pending, valid=%b expected 0 pending", exp_q.size(), id_valid_o);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_i = 1; flush_i = 0; if_valid_i = 0; if_instr_i = '0; if_pc_i = '0; id_ready_i = 0;
    test_reset();
    test_addi();
    test_back_to_back();
    test_branch_jal();
    test_illegal();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
